// File: rtl/pulse_sched_pkg.sv
// Shared types and default build parameters for the pulse scheduler.
package pulse_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP
   } state_e;

   localparam int N_REQ_DEF       = 4;
   localparam int PULSE_WIDTH_DEF = 200_000_000;
   localparam int GAP_CYCLES_DEF  = 10_000_000;
   localparam int CNT_W_DEF       = 29;

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one asynchronous trigger line.
module trig_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic trig_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic fill1_q;
   logic fill2_q;

   // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         fill1_q <= 1'b0;
         fill2_q <= 1'b0;
      end else begin
         meta_q  <= trig_i;
         sync_q  <= meta_q;
         // Until sync_q holds a real post-reset sample, seed prev_q with the value
         // entering sync_q so a line already high at release is not seen as an edge.
         prev_q  <= fill2_q ? sync_q : meta_q;
         fill1_q <= 1'b1;
         fill2_q <= fill1_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/pulse_scheduler.sv
// Round-robin scheduler that turns trigger edges from N_REQ requesters into one shared,
// stretched pulse followed by a forced low gap.
module pulse_scheduler
   import pulse_sched_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int PULSE_WIDTH = PULSE_WIDTH_DEF,
   parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           trigger,
   input  logic                       cancel,
   input  logic                       clr_drop,
   output logic                       pulse,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   active_id,
   output logic [N_REQ-1:0]           pending,
   output logic [N_REQ-1:0]           dropped
);

   localparam int ID_W = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               pulse_q;
   logic [ID_W-1:0]    active_q;
   logic [ID_W-1:0]    last_q;
   logic [N_REQ-1:0]   pend_q, pend_d;
   logic [N_REQ-1:0]   drop_q, drop_d;
   logic [N_REQ-1:0]   rise;
   logic [N_REQ-1:0]   clr_mask;
   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    grant_id;
   logic               grant_vld;
   logic               take;

   for (genvar i = 0; i < N_REQ; i++) begin : g_sync
      trig_sync_edge u_sync (
         .clk    (clk),
         .reset  (reset),
         .trig_i (trigger[i]),
         .rise_o (rise[i])
      );
   end

   // NOTE: every signal assigned here gets a default first, so no latches are inferred.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(last_q) + k) % N_REQ);
         if (!grant_vld && pend_q[cand]) begin
            grant_vld = 1'b1;
            grant_id  = cand;
         end
      end

      take     = (state_q == IDLE) && grant_vld;
      clr_mask = '0;
      if (take) clr_mask[grant_id] = 1'b1;

      // A fresh edge beats the grant clear; a re-trigger of the channel being granted is not a drop.
      pend_d = (pend_q & ~clr_mask) | rise;
      drop_d = (clr_drop ? '0 : drop_q) | (rise & pend_q & ~clr_mask);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pulse_q  <= 1'b0;
         active_q <= '0;
         last_q   <= ID_W'(N_REQ - 1);
         pend_q   <= '0;
         drop_q   <= '0;
      end else begin
         pend_q <= pend_d;
         drop_q <= drop_d;
         case (state_q)
            IDLE: begin
               if (take) begin
                  state_q  <= PULSE;
                  pulse_q  <= 1'b1;
                  active_q <= grant_id;
                  last_q   <= grant_id;
                  cnt_q    <= '0;
               end
            end
            PULSE: begin
               if (cancel || cnt_q == PW_LAST) begin
                  pulse_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               pulse_q <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign pulse     = pulse_q;
   assign busy      = (state_q != IDLE);
   assign active_id = active_q;
   assign pending   = pend_q;
   assign dropped   = drop_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: two builds (gap 3 and gap 0) driven together and compared
// every cycle against a countdown-based reference model, plus directed scenario checks.
module tb_pulse_scheduler;

   localparam int N  = 4;
   localparam int PW = 8;
   localparam int CW = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         cancel = 1'b0;
   logic         clr_drop = 1'b0;
   logic [N-1:0] trigger = '0;

   logic         pulse_a, busy_a, pulse_b, busy_b;
   logic [1:0]   id_a, id_b;
   logic [N-1:0] pend_a, drop_a, pend_b, drop_b;

   pulse_scheduler #(.N_REQ(N), .PULSE_WIDTH(PW), .GAP_CYCLES(3), .CNT_W(CW)) dut_a (
      .clk(clk), .reset(reset), .trigger(trigger), .cancel(cancel), .clr_drop(clr_drop),
      .pulse(pulse_a), .busy(busy_a), .active_id(id_a), .pending(pend_a), .dropped(drop_a)
   );

   pulse_scheduler #(.N_REQ(N), .PULSE_WIDTH(PW), .GAP_CYCLES(0), .CNT_W(CW)) dut_b (
      .clk(clk), .reset(reset), .trigger(trigger), .cancel(cancel), .clr_drop(clr_drop),
      .pulse(pulse_b), .busy(busy_b), .active_id(id_b), .pending(pend_b), .dropped(drop_b)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: pulse/gap expressed as remaining-cycle countdowns.
   int           m_pl[2];
   int           m_gl[2];
   int           m_last[2];
   int           m_act[2];
   logic [N-1:0] m_pend[2];
   logic [N-1:0] m_drop[2];
   logic [N-1:0] hist[$];

   logic pa_prev = 1'b0;
   int   rises_a[N];
   int   order_a[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] rise;
      logic [N-1:0] gmask;
      int           g;
      if (!reset) begin
         hist.delete();
         for (int m = 0; m < 2; m++) begin
            m_pl[m] = 0; m_gl[m] = 0; m_last[m] = N - 1; m_act[m] = 0;
            m_pend[m] = '0; m_drop[m] = '0;
         end
         return;
      end
      hist.push_back(trigger);
      rise = '0;
      // Edge needs two post-reset samples: low at n-3, high at n-2.
      if (hist.size() >= 4) rise = hist[hist.size()-3] & ~hist[hist.size()-4];
      if (hist.size() > 4) void'(hist.pop_front());
      for (int m = 0; m < 2; m++) begin
         g     = (m == 0) ? 3 : 0;
         gmask = '0;
         if (m_pl[m] == 0 && m_gl[m] == 0 && m_pend[m] != '0) begin
            for (int k = 1; k <= N; k++) begin
               if (gmask == '0 && m_pend[m][(m_last[m] + k) % N]) begin
                  gmask[(m_last[m] + k) % N] = 1'b1;
                  m_act[m]  = (m_last[m] + k) % N;
               end
            end
            m_last[m] = m_act[m];
            m_pl[m]   = PW;
         end else if (m_pl[m] > 0) begin
            if (cancel || m_pl[m] == 1) begin
               m_pl[m] = 0;
               m_gl[m] = g;
            end else begin
               m_pl[m]--;
            end
         end else if (m_gl[m] > 0) begin
            m_gl[m]--;
         end
         m_drop[m] = (clr_drop ? '0 : m_drop[m]) | (rise & m_pend[m] & ~gmask);
         m_pend[m] = (m_pend[m] & ~gmask) | rise;
      end
   endtask

   task automatic cmp(input string d, input int m, input logic p, input logic b,
                      input logic [1:0] id, input logic [N-1:0] pe, input logic [N-1:0] dr);
      check({d, ".pulse"},   p,  m_pl[m] > 0);
      check({d, ".busy"},    b,  (m_pl[m] > 0) || (m_gl[m] > 0));
      check({d, ".id"},      id, m_act[m]);
      check({d, ".pending"}, pe, m_pend[m]);
      check({d, ".dropped"}, dr, m_drop[m]);
   endtask

   task automatic cyc(input logic [N-1:0] trg, input logic canc, input logic clr, input logic rst_v);
      @(negedge clk);
      trigger  = trg;
      cancel   = canc;
      clr_drop = clr;
      reset    = rst_v;
      @(posedge clk);
      #1;
      model_edge();
      cmp("a", 0, pulse_a, busy_a, id_a, pend_a, drop_a);
      cmp("b", 1, pulse_b, busy_b, id_b, pend_b, drop_b);
      if (pulse_a && !pa_prev) begin
         rises_a[id_a]++;
         order_a.push_back(int'(id_a));
      end
      pa_prev = pulse_a;
   endtask

   task automatic clear_stats();
      for (int k = 0; k < N; k++) rises_a[k] = 0;
      order_a.delete();
   endtask

   task automatic do_reset();
      cyc('0, 1'b0, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0, 1'b1);
      cyc('0, 1'b0, 1'b0, 1'b1);
      clear_stats();
   endtask

   // Clocks the held trigger pattern until pulse_a is high, bounded.
   task automatic wait_pulse(input logic [N-1:0] trg, input string tag);
      int n = 0;
      while (!pulse_a && n < 30) begin
         cyc(trg, 1'b0, 1'b0, 1'b1);
         n++;
      end
      check({tag, ".wait_pulse"}, pulse_a, 1'b1);
   endtask

   initial begin
      int           first;
      int           highs;
      int           busys;
      int           b_low;
      bit           b_seen;
      logic         pb_prev;
      logic [N-1:0] trg;

      // Reset state
      do_reset();
      check("rst.pending", pend_a, 0);
      check("rst.busy", busy_a, 0);

      // Single request on channel 2
      first = -1; highs = 0; busys = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(4'b0100, 1'b0, 1'b0, 1'b1);
         if (pulse_a && first < 0) first = i;
         if (pulse_a) highs++;
         if (busy_a) busys++;
      end
      check("single.latency", first, 3);
      check("single.width", highs, PW);
      check("single.busy", busys, PW + 3);
      check("single.id", rises_a[2], 1);
      cyc('0, 1'b0, 1'b0, 1'b1);

      // All four channels at once: round-robin 0,1,2,3; gap-0 build low one cycle between pulses
      do_reset();
      b_low = 0; b_seen = 0; pb_prev = 1'b0;
      for (int i = 0; i < 70; i++) begin
         cyc(4'b1111, 1'b0, 1'b0, 1'b1);
         if (pulse_b) begin
            if (!pb_prev && b_seen) check("gap0.low_run", b_low, 1);
            b_seen = 1;
            b_low  = 0;
         end else begin
            b_low++;
         end
         pb_prev = pulse_b;
      end
      check("rr.count", order_a.size(), 4);
      for (int k = 0; k < order_a.size(); k++) check("rr.order", order_a[k], k);

      // Double edge on pending channel 1 while channel 0 is served
      do_reset();
      for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) cyc(4'b0011, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) cyc(4'b0001, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) cyc(4'b0011, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(4'b0001, 1'b0, 1'b0, 1'b1);
      check("drop.set", drop_a, 4'b0010);
      for (int i = 0; i < 25; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b1);
      check("drop.one_pulse", rises_a[1], 1);
      cyc(4'b0000, 1'b0, 1'b1, 1'b1);
      check("drop.clear", drop_a, 4'b0000);

      // Cancel in the 4th pulse cycle, then next pending channel is granted after the gap
      do_reset();
      wait_pulse(4'b0011, "cancel");
      for (int i = 0; i < 3; i++) cyc(4'b0011, 1'b0, 1'b0, 1'b1);
      cyc(4'b0011, 1'b1, 1'b0, 1'b1);
      check("cancel.pulse_low", pulse_a, 1'b0);
      check("cancel.in_gap", busy_a, 1'b1);
      for (int i = 0; i < 4; i++) cyc(4'b0011, 1'b0, 1'b0, 1'b1);
      check("cancel.next_pulse", pulse_a, 1'b1);
      check("cancel.next_id", id_a, 1);

      // Reset in pulse cycle 5 with requests queued; held triggers must not re-request
      do_reset();
      wait_pulse(4'b0111, "rstmid");
      for (int i = 0; i < 4; i++) cyc(4'b0111, 1'b0, 1'b0, 1'b1);
      cyc(4'b0111, 1'b0, 1'b0, 1'b0);
      check("rstmid.pulse", pulse_a, 1'b0);
      check("rstmid.pending", pend_a, 0);
      highs = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(4'b0111, 1'b0, 1'b0, 1'b1);
         if (pulse_a) highs++;
      end
      check("rstmid.no_pulse", highs, 0);

      // Randomised traffic against the model
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         trg = trigger;
         for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) trg[b] = ~trg[b];
         cyc(trg, ($urandom_range(19) == 0), ($urandom_range(24) == 0),
             ($urandom_range(299) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
